vend_dispense_scheduler: RTL

//   Shares one product-motor driver and one change hopper between N_LANES vending FSM lanes.

---
 rtl/vend_dispense_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vend_dispense_scheduler.sv
`default_nettype none
// ============================================================================
// vend_dispense_scheduler : round-robin sharing of one motor driver and one
// change hopper between vending lanes, with per-lane pending request queues.
// Revision: 1.0
// ============================================================================
module vend_dispense_scheduler #(
  parameter int N_LANES    = 4,
  parameter int MOTOR_CYC  = 8,
  parameter int HOPPER_CYC = 4,
  parameter int PEND_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_LANES-1:0]         prod_req,
  input  logic [N_LANES-1:0]         change_req,
  output logic [N_LANES-1:0]         motor_en,
  output logic                       hopper_en,
  output logic [$clog2(N_LANES)-1:0] grant_lane,
  output logic                       busy,
  output logic                       vend_done,
  output logic [N_LANES-1:0]         overflow
);

  localparam int LANE_W  = $clog2(N_LANES);
  localparam int TMR_MAX = (MOTOR_CYC > HOPPER_CYC) ? MOTOR_CYC : HOPPER_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0]  MOTOR_LOAD  = TMR_W'(MOTOR_CYC - 1);
  localparam logic [TMR_W-1:0]  HOPPER_LOAD = TMR_W'(HOPPER_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX    = '1;
  localparam logic [LANE_W-1:0] LAST_RST    = LANE_W'(N_LANES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOTOR  = 2'd1;
  localparam logic [1:0] S_HOPPER = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]        state;
  logic [TMR_W-1:0]  timer;
  logic [LANE_W-1:0] last;
  logic              take_chg;
  logic [PEND_W-1:0] pend_prod [N_LANES];
  logic [PEND_W-1:0] pend_chg  [N_LANES];

  logic              found;
  logic [LANE_W-1:0] pick;
  logic [LANE_W-1:0] rr_idx;
  logic              grant_go;
  logic [N_LANES-1:0] dec_prod;
  logic [N_LANES-1:0] dec_chg;
  logic [N_LANES-1:0] chg_nz;
  logic [N_LANES-1:0] prod_drop;
  logic [N_LANES-1:0] inc_chg;

  // Round-robin search starting one past the last served lane.
  always_comb begin
    found  = 1'b0;
    pick   = last;
    rr_idx = '0;
    for (int k = 1; k <= N_LANES; k++) begin
      rr_idx = LANE_W'((int'(last) + k) % N_LANES);
      if (!found && (pend_prod[rr_idx] != '0)) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  always_comb begin
    chg_nz    = '0;
    prod_drop = '0;
    for (int i = 0; i < N_LANES; i++) begin
      chg_nz[i] = (pend_chg[i] != '0);
    end
    grant_go = (state == S_IDLE) && found;
    dec_prod = grant_go ? (N_LANES'(1) << pick) : '0;
    dec_chg  = dec_prod & chg_nz;
    for (int i = 0; i < N_LANES; i++) begin
      prod_drop[i] = prod_req[i] && !dec_prod[i] && (pend_prod[i] == PEND_MAX);
    end
    // A dropped product must not leave change owed behind it.
    inc_chg = prod_req & change_req & ~prod_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) begin
        pend_prod[i] <= '0;
        pend_chg[i]  <= '0;
      end
      overflow <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (prod_drop[i]) begin
          overflow[i] <= 1'b1;
        end else if (prod_req[i] && !dec_prod[i]) begin
          pend_prod[i] <= pend_prod[i] + 1'b1;
        end else if (!prod_req[i] && dec_prod[i]) begin
          pend_prod[i] <= pend_prod[i] - 1'b1;
        end

        if (inc_chg[i] && !dec_chg[i]) begin
          pend_chg[i] <= pend_chg[i] + 1'b1;
        end else if (!inc_chg[i] && dec_chg[i]) begin
          pend_chg[i] <= pend_chg[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      last       <= LAST_RST;
      grant_lane <= '0;
      take_chg   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state      <= S_MOTOR;
            timer      <= MOTOR_LOAD;
            last       <= pick;
            grant_lane <= pick;
            take_chg   <= chg_nz[pick];
          end
        end
        S_MOTOR: begin
          if (timer == '0) begin
            if (take_chg) begin
              state <= S_HOPPER;
              timer <= HOPPER_LOAD;
            end else begin
              state <= S_GAP;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_HOPPER: begin
          if (timer == '0) begin
            state <= S_GAP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign motor_en  = (state == S_MOTOR) ? (N_LANES'(1) << grant_lane) : '0;
  assign hopper_en = (state == S_HOPPER);
  assign vend_done = (state == S_GAP);
  assign busy      = (state != S_IDLE);

endmodule
`default_nettype wire
